// File: rtl/trap_sequencer_if.sv
// Trap sequencer bus: pipeline trap events and CSR values in, CSR secondary
// write port plus pipeline stall/redirect controls out.
interface trap_sequencer_if;
  logic        exc_valid;
  logic [31:0] exc_cause;
  logic [31:0] exc_pc;
  logic [31:0] exc_tval;
  logic        mret_valid;
  logic        irq;
  logic [31:0] int_pc;
  logic        ex_csr_we;
  logic [31:0] csr_mtvec;
  logic [31:0] csr_mepc;
  logic [31:0] csr_mstatus;
  logic        csr_we_clint;
  logic [11:0] csr_waddr_clint;
  logic [31:0] csr_wdata_clint;
  logic        hold;
  logic        jump;
  logic [31:0] jump_addr;
  logic        busy;

  modport slave (
    input  exc_valid, exc_cause, exc_pc, exc_tval, mret_valid, irq, int_pc,
           ex_csr_we, csr_mtvec, csr_mepc, csr_mstatus,
    output csr_we_clint, csr_waddr_clint, csr_wdata_clint, hold, jump,
           jump_addr, busy
  );

  modport master (
    output exc_valid, exc_cause, exc_pc, exc_tval, mret_valid, irq, int_pc,
           ex_csr_we, csr_mtvec, csr_mepc, csr_mstatus,
    input  csr_we_clint, csr_waddr_clint, csr_wdata_clint, hold, jump,
           jump_addr, busy
  );
endinterface

// File: rtl/trap_sequencer.sv
// Trap/MRET sequencer: serialises machine-mode CSR updates and the redirect.
// Define TRAP_VECTORED_EN to vector interrupts when mtvec[1:0] == 2'b01.
module trap_sequencer (
  input logic              clk,
  input logic              rst,
  trap_sequencer_if.slave  bus
);
  typedef enum logic [2:0] {
    IDLE, W_MEPC, W_MCAUSE, W_MTVAL, W_MSTATUS, R_MSTATUS, JUMP
  } state_t;

  state_t      state, state_nxt;
  logic [31:0] cause_q, mepc_q, tval_q, mstatus_q;
  logic        mret_q, irq_q;
  logic        idle, acc_exc, acc_mret, acc_irq;
  logic [31:0] trap_mstatus, mret_mstatus, trap_base, trap_target;

  // rst gates acceptance so hold stays low while reset is asserted
  assign idle     = (state == IDLE) && !rst;
  assign acc_exc  = idle && bus.exc_valid;
  assign acc_mret = idle && !bus.exc_valid && bus.mret_valid;
  assign acc_irq  = idle && !bus.exc_valid && !bus.mret_valid &&
                    bus.irq && bus.csr_mstatus[3];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cause_q   <= '0;
      mepc_q    <= '0;
      tval_q    <= '0;
      mstatus_q <= '0;
      mret_q    <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      state <= state_nxt;
      if (acc_exc || acc_mret || acc_irq) begin
        cause_q   <= acc_exc ? bus.exc_cause : (acc_irq ? 32'h8000_000B : 32'h0);
        mepc_q    <= acc_exc ? bus.exc_pc    : (acc_irq ? bus.int_pc    : 32'h0);
        tval_q    <= acc_exc ? bus.exc_tval  : 32'h0;
        mstatus_q <= bus.csr_mstatus;
        mret_q    <= acc_mret;
        irq_q     <= acc_irq;
      end
    end
  end

  // trap: MPIE<=MIE, MIE<=0, MPP<=M ; mret: MIE<=MPIE, MPIE<=1, MPP<=M
  assign trap_mstatus = {mstatus_q[31:13], 2'b11, mstatus_q[10:8], mstatus_q[3],
                         mstatus_q[6:4], 1'b0, mstatus_q[2:0]};
  assign mret_mstatus = {mstatus_q[31:13], 2'b11, mstatus_q[10:8], 1'b1,
                         mstatus_q[6:4], mstatus_q[7], mstatus_q[2:0]};
  assign trap_base    = {bus.csr_mtvec[31:2], 2'b00};

`ifdef TRAP_VECTORED_EN
  assign trap_target = (irq_q && bus.csr_mtvec[1:0] == 2'b01) ?
                       trap_base + {cause_q[29:0], 2'b00} : trap_base;
`else
  logic unused_mtvec_mode;
  assign unused_mtvec_mode = ^{bus.csr_mtvec[1:0], irq_q};
  assign trap_target = trap_base;
`endif

  always_comb begin
    state_nxt           = state;
    bus.csr_we_clint    = 1'b0;
    bus.csr_waddr_clint = 12'h0;
    bus.csr_wdata_clint = 32'h0;
    bus.hold            = (state != IDLE);
    bus.jump            = 1'b0;
    bus.jump_addr       = 32'h0;
    case (state)
      IDLE: begin
        bus.hold = acc_exc || acc_mret || acc_irq;
        if (acc_exc || acc_irq) state_nxt = W_MEPC;
        else if (acc_mret)      state_nxt = R_MSTATUS;
      end
      W_MEPC, W_MCAUSE, W_MTVAL, W_MSTATUS, R_MSTATUS: begin
        // the EX stage owns the CSR file this cycle; retry next cycle
        if (!bus.ex_csr_we) begin
          bus.csr_we_clint = 1'b1;
          case (state)
            W_MEPC:    begin bus.csr_waddr_clint = 12'h341; bus.csr_wdata_clint = mepc_q;       state_nxt = W_MCAUSE;  end
            W_MCAUSE:  begin bus.csr_waddr_clint = 12'h342; bus.csr_wdata_clint = cause_q;      state_nxt = W_MTVAL;   end
            W_MTVAL:   begin bus.csr_waddr_clint = 12'h343; bus.csr_wdata_clint = tval_q;       state_nxt = W_MSTATUS; end
            W_MSTATUS: begin bus.csr_waddr_clint = 12'h300; bus.csr_wdata_clint = trap_mstatus; state_nxt = JUMP;      end
            default:   begin bus.csr_waddr_clint = 12'h300; bus.csr_wdata_clint = mret_mstatus; state_nxt = JUMP;      end
          endcase
        end
      end
      JUMP: begin
        bus.jump      = 1'b1;
        bus.jump_addr = mret_q ? bus.csr_mepc : trap_target;
        state_nxt     = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.busy = (state != IDLE);
endmodule

// File: tb/tb_trap_sequencer.sv
// Randomized + directed bench for trap_sequencer against a queue-of-pending-
// actions reference model; honours TRAP_VECTORED_EN like the design.
module tb_trap_sequencer;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  trap_sequencer_if bus ();
  trap_sequencer dut (.clk(clk), .rst(rst), .bus(bus));

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int njump = 0;
  int last_jump_cyc = 0;
  logic [31:0] last_ja = '0;

  // one pending action of an accepted event: either a CSR write or the jump
  typedef struct {
    logic        is_jump;
    logic [11:0] a;
    logic [31:0] d;
    logic        mret;
    logic        irq_src;
    logic [31:0] cause;
  } act_t;
  act_t q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  function automatic act_t wr(input logic [11:0] a, input logic [31:0] d);
    act_t t;
    t = '{is_jump: 1'b0, a: a, d: d, mret: 1'b0, irq_src: 1'b0, cause: 32'h0};
    return t;
  endfunction

  task automatic push_trap(input logic [31:0] cause, input logic [31:0] pc,
                           input logic [31:0] tval, input logic is_irq, input logic [31:0] ms);
    logic [31:0] nms;
    act_t j;
    nms = ms & ~32'h0000_1888;
    nms = nms | 32'h1800 | (ms[3] ? 32'h80 : 32'h0);
    q.push_back(wr(12'h341, pc));
    q.push_back(wr(12'h342, cause));
    q.push_back(wr(12'h343, tval));
    q.push_back(wr(12'h300, nms));
    j = '{is_jump: 1'b1, a: 12'h0, d: 32'h0, mret: 1'b0, irq_src: is_irq, cause: cause};
    q.push_back(j);
  endtask

  task automatic push_mret(input logic [31:0] ms);
    logic [31:0] nms;
    act_t j;
    nms = (ms & ~32'h0000_1888) | 32'h1880 | (ms[7] ? 32'h8 : 32'h0);
    q.push_back(wr(12'h300, nms));
    j = '{is_jump: 1'b1, a: 12'h0, d: 32'h0, mret: 1'b1, irq_src: 1'b0, cause: 32'h0};
    q.push_back(j);
  endtask

  task automatic model_check();
    logic        e_we, e_hold, e_jump, e_busy;
    logic [11:0] e_wa;
    logic [31:0] e_wd, e_ja, base;
    e_we = 0; e_hold = 0; e_jump = 0; e_busy = 0; e_wa = 0; e_wd = 0; e_ja = 0;
    if (rst) begin
      q.delete();
    end else if (q.size() != 0) begin
      e_busy = 1; e_hold = 1;
      if (q[0].is_jump) begin
        base = bus.csr_mtvec & 32'hFFFF_FFFC;
`ifdef TRAP_VECTORED_EN
        if (q[0].irq_src && bus.csr_mtvec[1:0] == 2'b01)
          base = base + 32'd4 * {1'b0, q[0].cause[30:0]};
`endif
        e_jump = 1;
        e_ja = q[0].mret ? bus.csr_mepc : base;
        void'(q.pop_front());
      end else if (!bus.ex_csr_we) begin
        e_we = 1; e_wa = q[0].a; e_wd = q[0].d;
        void'(q.pop_front());
      end
    end else begin
      if (bus.exc_valid)
        push_trap(bus.exc_cause, bus.exc_pc, bus.exc_tval, 1'b0, bus.csr_mstatus);
      else if (bus.mret_valid)
        push_mret(bus.csr_mstatus);
      else if (bus.irq && bus.csr_mstatus[3])
        push_trap(32'h8000_000B, bus.int_pc, 32'h0, 1'b1, bus.csr_mstatus);
      e_hold = (q.size() != 0);
    end
    chk("we",    {31'h0, bus.csr_we_clint}, {31'h0, e_we});
    chk("waddr", {20'h0, bus.csr_waddr_clint}, {20'h0, e_wa});
    chk("wdata", bus.csr_wdata_clint, e_wd);
    chk("hold",  {31'h0, bus.hold}, {31'h0, e_hold});
    chk("jump",  {31'h0, bus.jump}, {31'h0, e_jump});
    chk("jaddr", bus.jump_addr, e_ja);
    chk("busy",  {31'h0, bus.busy}, {31'h0, e_busy});
    if (bus.jump === 1'b1) begin
      njump++; last_ja = bus.jump_addr; last_jump_cyc = cyc;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    model_check();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic quiet();
    bus.exc_valid = 0; bus.mret_valid = 0; bus.irq = 0; bus.ex_csr_we = 0;
  endtask

  task automatic idle_n(input int n);
    quiet();
    for (int k = 0; k < n; k++) tick();
  endtask

  int c0;
  int nj0;

  initial begin
    rst = 1;
    quiet();
    bus.exc_cause = 0; bus.exc_pc = 0; bus.exc_tval = 0; bus.int_pc = 0;
    bus.csr_mtvec = 0; bus.csr_mepc = 0; bus.csr_mstatus = 0;
    bus.exc_valid = 1; bus.irq = 1; bus.csr_mstatus = 32'h8;
    tick(); tick();                          // outputs must stay 0 under reset
    rst = 0;
    idle_n(2);

    // exception with fixed operands
    bus.csr_mtvec = 32'h100; bus.csr_mstatus = 32'h8;
    bus.exc_cause = 2; bus.exc_pc = 32'h40; bus.exc_tval = 32'h13;
    c0 = cyc; bus.exc_valid = 1; tick(); bus.exc_valid = 0;
    idle_n(6);
    chk("exc_lat", last_jump_cyc - c0, 5);
    chk("exc_addr", last_ja, 32'h100);

    // mret
    bus.csr_mstatus = 32'h1880; bus.csr_mepc = 32'h44;
    c0 = cyc; bus.mret_valid = 1; tick(); bus.mret_valid = 0;
    idle_n(3);
    chk("mret_lat", last_jump_cyc - c0, 2);
    chk("mret_addr", last_ja, 32'h44);

    // EX-stage write conflict on cycles 2-3
    bus.csr_mstatus = 32'h8;
    c0 = cyc; bus.exc_valid = 1; tick(); bus.exc_valid = 0;
    tick();
    bus.ex_csr_we = 1; tick(); tick(); bus.ex_csr_we = 0;
    idle_n(5);
    chk("conf_lat", last_jump_cyc - c0, 7);

    // interrupt masked, then enabled
    bus.csr_mstatus = 32'h0; bus.int_pc = 32'h88; bus.irq = 1;
    tick(); tick();
    bus.csr_mstatus = 32'h8; c0 = cyc; tick(); bus.irq = 0;
    idle_n(6);
    chk("irq_lat", last_jump_cyc - c0, 5);

    // all events together, reset during W_MTVAL
    bus.csr_mstatus = 32'h8;
    bus.exc_valid = 1; bus.mret_valid = 1; bus.irq = 1; tick();
    quiet(); tick(); tick();
    nj0 = njump;
    rst = 1; tick(); tick();
    rst = 0; idle_n(8);
    chk("rst_nojump", njump - nj0, 0);

    // vectored interrupt target
    bus.csr_mtvec = 32'h201; bus.csr_mstatus = 32'h8; bus.irq = 1;
    tick(); bus.irq = 0;
    idle_n(6);
`ifdef TRAP_VECTORED_EN
    chk("vec_addr", last_ja, 32'h22C);
`else
    chk("vec_addr", last_ja, 32'h200);
`endif

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      rst             = ($urandom_range(0, 99) < 2);
      bus.exc_valid   = ($urandom_range(0, 99) < 15);
      bus.mret_valid  = ($urandom_range(0, 99) < 15);
      bus.irq         = ($urandom_range(0, 99) < 30);
      bus.ex_csr_we   = ($urandom_range(0, 99) < 30);
      bus.exc_cause   = $urandom;
      bus.exc_pc      = $urandom;
      bus.exc_tval    = $urandom;
      bus.int_pc      = $urandom;
      bus.csr_mtvec   = $urandom;
      bus.csr_mepc    = $urandom;
      bus.csr_mstatus = $urandom;
      tick();
    end
    rst = 0;
    idle_n(10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
